reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 34 +++
 rtl/reorder_buffer_rob_ptr.sv | 31 +++
 rtl/reorder_buffer.sv | 174 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: decoded ROB entry, CDB broadcast
// packet, default sizing and the branch-mispredict helper.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH = 8;
   localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
   localparam int ROB_XLEN  = 32;

   // Decoded instruction as handed over by the issue stage
   typedef struct packed {
      logic [4:0]  rd;
      logic        reg_write;
      logic        is_branch;
      logic [31:0] pc;
      logic [31:0] imm_se;
      logic        predicted_taken;
   } ROB_entry_t;

   // Common data bus broadcast from the execution units
   typedef struct packed {
      logic                 valid;
      logic [ROB_TAG_W-1:0] tag;
      logic [ROB_XLEN-1:0]  value;
      logic                 branch_taken;
   } CDB_packet_t;

   // A retiring branch whose resolved direction differs from the prediction
   function automatic logic is_mispredict(input logic is_branch,
                                          input logic taken,
                                          input logic predicted);
      return is_branch & (taken != predicted);
   endfunction

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrap-around pointer into the reorder buffer (used for head and tail).
// Clear has priority over increment so a flush always lands on entry 0.
module rob_ptr
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [TAG_W-1:0] o_ptr
);

   logic [TAG_W-1:0] r_ptr;

   // Pointer register: clear, or step and wrap from DEPTH-1 back to 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == TAG_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation at the tail, out-of-order completion
// from the CDB, in-order retirement at the head, flush on a mispredicted
// branch at retirement.
// Optional macro ROB_BYPASS_EN: lookups see a same-cycle CDB result.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = $clog2(DEPTH),
   parameter int XLEN  = ROB_XLEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_valid,
   input  ROB_entry_t       alloc_entry,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  CDB_packet_t      cdb,
   input  logic [TAG_W-1:0] lookup_tag_j,
   input  logic [TAG_W-1:0] lookup_tag_k,
   output logic             lookup_rdy_j,
   output logic             lookup_rdy_k,
   output logic [XLEN-1:0]  lookup_val_j,
   output logic [XLEN-1:0]  lookup_val_k,
   output logic             commit_valid,
   output logic [4:0]       commit_rd,
   output logic             commit_reg_write,
   output logic [XLEN-1:0]  commit_value,
   output logic             commit_is_branch,
   output logic [31:0]      commit_pc,
   output logic [31:0]      commit_imm_se,
   output logic             commit_taken,
   output logic             commit_result,
   output logic             flush,
   output logic [TAG_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [TAG_W-1:0] w_head;
   logic [TAG_W-1:0] w_tail;
   logic [TAG_W-1:0] w_cdb_tag;
   logic             w_full;
   logic             w_commit;
   logic             w_flush;
   logic             w_alloc_fire;
   logic             w_cdb_fire;

   logic [TAG_W:0]   r_count;
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_ready;
   logic [DEPTH-1:0] r_taken;
   ROB_entry_t       r_entry [DEPTH];
   logic [XLEN-1:0]  r_value [DEPTH];

   assign w_cdb_tag    = TAG_W'(cdb.tag);
   assign w_full       = (r_count == (TAG_W + 1)'(DEPTH));
   assign w_commit     = r_valid[w_head] & r_ready[w_head];
   assign w_flush      = w_commit & is_mispredict(r_entry[w_head].is_branch,
                                                  r_taken[w_head],
                                                  r_entry[w_head].predicted_taken);
   // A flush discards whatever is offered in the same cycle
   assign w_alloc_fire = alloc_valid & ~w_full & ~w_flush;
   assign w_cdb_fire   = cdb.valid & r_valid[w_cdb_tag] & ~w_flush;

   rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_head (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_commit),
      .i_clr (w_flush),
      .o_ptr (w_head)
   );

   rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_tail (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_alloc_fire),
      .i_clr (w_flush),
      .o_ptr (w_tail)
   );

   // Entry status bits: allocate, complete, retire, or wipe on flush
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
         r_ready <= '0;
      end else if (w_flush) begin
         r_valid <= '0;
         r_ready <= '0;
      end else begin
         if (w_commit) begin
            r_valid[w_head] <= 1'b0;
         end
         if (w_alloc_fire) begin
            r_valid[w_tail] <= 1'b1;
            r_ready[w_tail] <= 1'b0;
         end
         if (w_cdb_fire) begin
            r_ready[w_cdb_tag] <= 1'b1;
         end
      end
   end

   // Payload storage; contents are only observed through set status bits
   always_ff @(posedge clk) begin
      if (w_alloc_fire) begin
         r_entry[w_tail] <= alloc_entry;
      end
      if (w_cdb_fire) begin
         r_value[w_cdb_tag] <= XLEN'(cdb.value);
         r_taken[w_cdb_tag] <= cdb.branch_taken;
      end
   end

   // Occupancy: alloc and commit in the same cycle cancel out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_flush) begin
         r_count <= '0;
      end else begin
         case ({w_alloc_fire, w_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Operand lookups, one combinational read per source operand
   for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
      logic [TAG_W-1:0] w_tag;
      logic             w_rdy;
      logic [XLEN-1:0]  w_val;

      assign w_tag = (gi == 0) ? lookup_tag_j : lookup_tag_k;

      // Stored result, optionally overridden by a matching CDB broadcast
      always_comb begin
         w_rdy = r_valid[w_tag] & r_ready[w_tag];
         w_val = w_rdy ? r_value[w_tag] : '0;
`ifdef ROB_BYPASS_EN
         if (cdb.valid && (w_cdb_tag == w_tag) && r_valid[w_tag]) begin
            w_rdy = 1'b1;
            w_val = XLEN'(cdb.value);
         end
`endif
      end
   end

   assign lookup_rdy_j = g_lookup[0].w_rdy;
   assign lookup_val_j = g_lookup[0].w_val;
   assign lookup_rdy_k = g_lookup[1].w_rdy;
   assign lookup_val_k = g_lookup[1].w_val;

   // Retirement outputs are zero whenever nothing retires
   assign commit_valid     = w_commit;
   assign commit_rd        = w_commit ? r_entry[w_head].rd : 5'd0;
   assign commit_reg_write = w_commit & r_entry[w_head].reg_write;
   assign commit_value     = w_commit ? r_value[w_head] : '0;
   assign commit_is_branch = w_commit & r_entry[w_head].is_branch;
   assign commit_pc        = w_commit ? r_entry[w_head].pc : 32'd0;
   assign commit_imm_se    = w_commit ? r_entry[w_head].imm_se : 32'd0;
   assign commit_taken     = commit_is_branch & r_taken[w_head];
   assign commit_result    = commit_is_branch & r_entry[w_head].predicted_taken;
   assign flush            = w_flush;

   assign alloc_ready = ~w_full;
   assign alloc_tag   = w_tail;
   assign count       = r_count;
   assign full        = w_full;
   assign empty       = (r_count == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/full, out-of-order completion,
// lookups with and without ROB_BYPASS_EN, flush, and asynchronous reset.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int DEPTH = 8;
   localparam int TAG_W = 3;
   localparam int XLEN  = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             alloc_valid;
   ROB_entry_t       alloc_entry;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   CDB_packet_t      cdb;
   logic [TAG_W-1:0] lookup_tag_j, lookup_tag_k;
   logic             lookup_rdy_j, lookup_rdy_k;
   logic [XLEN-1:0]  lookup_val_j, lookup_val_k;
   logic             commit_valid, commit_reg_write, commit_is_branch;
   logic [4:0]       commit_rd;
   logic [XLEN-1:0]  commit_value;
   logic [31:0]      commit_pc, commit_imm_se;
   logic             commit_taken, commit_result, flush;
   logic [TAG_W:0]   count;
   logic             full, empty;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk              (clk),
      .reset            (reset),
      .alloc_valid      (alloc_valid),
      .alloc_entry      (alloc_entry),
      .alloc_ready      (alloc_ready),
      .alloc_tag        (alloc_tag),
      .cdb              (cdb),
      .lookup_tag_j     (lookup_tag_j),
      .lookup_tag_k     (lookup_tag_k),
      .lookup_rdy_j     (lookup_rdy_j),
      .lookup_rdy_k     (lookup_rdy_k),
      .lookup_val_j     (lookup_val_j),
      .lookup_val_k     (lookup_val_k),
      .commit_valid     (commit_valid),
      .commit_rd        (commit_rd),
      .commit_reg_write (commit_reg_write),
      .commit_value     (commit_value),
      .commit_is_branch (commit_is_branch),
      .commit_pc        (commit_pc),
      .commit_imm_se    (commit_imm_se),
      .commit_taken     (commit_taken),
      .commit_result    (commit_result),
      .flush            (flush),
      .count            (count),
      .full             (full),
      .empty            (empty)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Just after the rising edge: safe point to change inputs
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Falling edge: sample outputs
   task automatic mid();
      @(negedge clk);
   endtask

   function automatic ROB_entry_t mk(input logic [4:0] rd, input logic wr, input logic br,
                                     input logic [31:0] pc, input logic [31:0] imm,
                                     input logic pt);
      ROB_entry_t e;
      e.rd              = rd;
      e.reg_write       = wr;
      e.is_branch       = br;
      e.pc              = pc;
      e.imm_se          = imm;
      e.predicted_taken = pt;
      return e;
   endfunction

   task automatic cdb_put(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val,
                          input logic taken);
      cdb.valid        = 1'b1;
      cdb.tag          = tag;
      cdb.value        = val;
      cdb.branch_taken = taken;
   endtask

   task automatic cdb_off();
      cdb = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      alloc_valid  = 1'b0;
      alloc_entry  = '0;
      cdb          = '0;
      lookup_tag_j = '0;
      lookup_tag_k = '0;

      // Reset state
      mid();
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_flush", flush, 0);
      chk("rst_lookup_val", lookup_val_j, 0);
      step();
      reset = 1'b0;

      // Fill all eight entries, then a ninth request is refused
      alloc_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         alloc_entry = mk(5'(i), 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
         mid();
         chk($sformatf("fill_tag%0d", i), alloc_tag, 64'(i));
         step();
      end
      alloc_entry = mk(5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      mid();
      chk("full_flag", full, 1);
      chk("full_alloc_ready", alloc_ready, 0);
      chk("full_count", count, 8);
      chk("full_tail", alloc_tag, 0);
      step();
      mid();
      chk("ninth_count", count, 8);
      chk("ninth_tail", alloc_tag, 0);

      // Full with head ready and alloc requested: commit yes, alloc no
      cdb_put(3'd0, 32'h1234, 1'b0);
      step();
      cdb_off();
      mid();
      chk("fullc_commit_valid", commit_valid, 1);
      chk("fullc_commit_value", commit_value, 32'h1234);
      chk("fullc_alloc_ready", alloc_ready, 0);
      step();
      mid();
      chk("fullc_count", count, 7);
      chk("fullc_tail", alloc_tag, 0);
      chk("fullc_full", full, 0);

      // Asynchronous reset between edges
      alloc_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_alloc_ready", alloc_ready, 1);
      chk("arst_tail", alloc_tag, 0);
      chk("arst_commit_valid", commit_valid, 0);
      step();
      reset = 1'b0;

      // Out-of-order completion, in-order commit
      alloc_valid = 1'b1;
      alloc_entry = mk(5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      alloc_entry = mk(5'd6, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      alloc_entry = mk(5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      alloc_valid = 1'b0;
      cdb_put(3'd2, 32'h22, 1'b0);
      step();
      cdb_put(3'd0, 32'h55, 1'b0);
      lookup_tag_j = 3'd2;
      lookup_tag_k = 3'd1;
      mid();
      chk("ooo_no_early_commit", commit_valid, 0);
      step();
      cdb_off();
      mid();
      chk("ooo_commit_valid", commit_valid, 1);
      chk("ooo_commit_value", commit_value, 32'h55);
      chk("ooo_commit_rd", commit_rd, 5);
      chk("ooo_commit_wr", commit_reg_write, 1);
      chk("ooo_commit_br", commit_is_branch, 0);
      chk("ooo_flush", flush, 0);
      chk("lk_rdy_j_tag2", lookup_rdy_j, 1);
      chk("lk_val_j_tag2", lookup_val_j, 32'h22);
      chk("lk_rdy_k_tag1", lookup_rdy_k, 0);
      step();
      mid();
      chk("ooo_tag2_waits", commit_valid, 0);
      chk("ooo_count", count, 2);

      // Lookup in the same cycle as the CDB write
      alloc_valid = 1'b1;
      alloc_entry = mk(5'd8, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      alloc_valid = 1'b0;
      cdb_put(3'd3, 32'hAB, 1'b0);
      lookup_tag_j = 3'd3;
      mid();
`ifdef ROB_BYPASS_EN
      chk("byp_rdy_same_cycle", lookup_rdy_j, 1);
      chk("byp_val_same_cycle", lookup_val_j, 32'hAB);
`else
      chk("byp_rdy_same_cycle", lookup_rdy_j, 0);
      chk("byp_val_same_cycle", lookup_val_j, 0);
`endif
      step();
      cdb_off();
      mid();
      chk("byp_rdy_next", lookup_rdy_j, 1);
      chk("byp_val_next", lookup_val_j, 32'hAB);

      // Drain tags 1, 2, 3 in order
      cdb_put(3'd1, 32'h11, 1'b0);
      step();
      cdb_off();
      mid();
      chk("drain1_value", commit_value, 32'h11);
      chk("drain1_rd", commit_rd, 6);
      step();
      mid();
      chk("drain2_value", commit_value, 32'h22);
      chk("drain2_rd", commit_rd, 7);
      step();
      mid();
      chk("drain3_value", commit_value, 32'hAB);
      chk("drain3_rd", commit_rd, 8);
      step();
      mid();
      chk("drain_empty", empty, 1);
      chk("drain_count", count, 0);
      chk("drain_tail", alloc_tag, 4);

      // Mispredicted branch at head flushes younger entry
      alloc_valid = 1'b1;
      alloc_entry = mk(5'd0, 1'b0, 1'b1, 32'h100, 32'h20, 1'b1);
      step();
      alloc_entry = mk(5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      step();
      alloc_valid = 1'b0;
      cdb_put(3'd4, 32'h0, 1'b0);
      step();
      alloc_valid = 1'b1;
      cdb_put(3'd5, 32'h77, 1'b0);
      mid();
      chk("mp_commit_valid", commit_valid, 1);
      chk("mp_is_branch", commit_is_branch, 1);
      chk("mp_result", commit_result, 1);
      chk("mp_taken", commit_taken, 0);
      chk("mp_flush", flush, 1);
      chk("mp_pc", commit_pc, 32'h100);
      chk("mp_imm", commit_imm_se, 32'h20);
      chk("mp_count", count, 2);
      step();
      alloc_valid = 1'b0;
      cdb_off();
      lookup_tag_k = 3'd5;
      mid();
      chk("mp_flush_after", flush, 0);
      chk("mp_count_after", count, 0);
      chk("mp_empty_after", empty, 1);
      chk("mp_tail_after", alloc_tag, 0);
      chk("mp_commit_after", commit_valid, 0);
      chk("mp_lk_tag5", lookup_rdy_k, 0);

      // Correctly predicted branch: no flush
      alloc_valid = 1'b1;
      alloc_entry = mk(5'd0, 1'b0, 1'b1, 32'h200, 32'h8, 1'b1);
      step();
      alloc_valid = 1'b0;
      cdb_put(3'd0, 32'h0, 1'b1);
      step();
      cdb_off();
      mid();
      chk("okbr_commit", commit_valid, 1);
      chk("okbr_taken", commit_taken, 1);
      chk("okbr_result", commit_result, 1);
      chk("okbr_flush", flush, 0);

      // Non-branch with taken set on the CDB reports no branch info
      alloc_valid = 1'b1;
      alloc_entry = mk(5'd3, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      step();
      alloc_valid = 1'b0;
      cdb_put(3'd1, 32'h5, 1'b1);
      step();
      cdb_off();
      mid();
      chk("nb_commit", commit_valid, 1);
      chk("nb_taken", commit_taken, 0);
      chk("nb_result", commit_result, 0);
      chk("nb_flush", flush, 0);
      chk("nb_value", commit_value, 32'h5);
      step();
      mid();
      chk("nb_count_end", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
